// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_pkg
//  Description : Shared operation codes, look-ahead block size and the
//                group propagate/generate helper for the pipelined add/sub.
//  Revision    : 1.0  initial release
// ============================================================================
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Bits per carry-look-ahead block.
    localparam int BLK = 4;

    // Group propagate/generate of one look-ahead block.
    typedef struct packed {
        logic p;
        logic g;
    } grp_pg_t;

    // Group P is the AND of all bit propagates; group G folds from the LSB
    // upward so that a generate survives only through propagating bits above it.
    function automatic grp_pg_t blk_pg(input logic [BLK-1:0] p, input logic [BLK-1:0] g);
        grp_pg_t r;
        r.p = &p;
        r.g = 1'b0;
        for (int i = 0; i < BLK; i++) begin
            r.g = g[i] | (p[i] & r.g);
        end
        return r;
    endfunction

endpackage : addsub_pkg
`default_nettype wire

// File: rtl/cla_blk4_pg.sv
`default_nettype none
// ============================================================================
//  Module      : cla_blk4_pg
//  Description : 4-bit carry-look-ahead block. Produces the three carries
//                internal to the block and the block P/G for the next level.
//  Revision    : 1.0  initial release
// ============================================================================
module cla_blk4_pg
    import addsub_pkg::*;
(
    input  logic [BLK-1:0] p_i,
    input  logic [BLK-1:0] g_i,
    input  logic           cin_i,
    output logic [BLK-2:0] c_o,    // carries into bits 1..3 of the block
    output logic           bp_o,
    output logic           bg_o
);

    grp_pg_t w_pg;

    assign w_pg = blk_pg(p_i, g_i);
    assign bp_o = w_pg.p;
    assign bg_o = w_pg.g;

    // Flat two-level carries; block P/G does not depend on cin_i, so the
    // upper look-ahead level never waits on this block's carry-in.
    always_comb begin
        c_o[0] = g_i[0] | (p_i[0] & cin_i);
        c_o[1] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & cin_i);
        c_o[2] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0])
               | (p_i[2] & p_i[1] & p_i[0] & cin_i);
    end

endmodule : cla_blk4_pg
`default_nettype wire

// File: rtl/pipe_addsub_32.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_addsub_32
//  Description : Two-stage pipelined adder/subtractor with valid/ready on
//                both sides. Stage 1 adds the low half and registers the
//                carry into bit WIDTH/2; stage 2 adds the high half.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_addsub_32
    import addsub_pkg::*;
#(
    parameter int WIDTH = 32        // even and a multiple of 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int HALF = WIDTH / 2;
    localparam int NBLK = HALF / BLK;

    // ---------------- stage 1: operand prep and low-half add ----------------
    logic [WIDTH-1:0] w_b_eff;
    logic [HALF-1:0]  w_lo_p, w_lo_g, w_lo_c, w_lo_sum;
    logic [NBLK-1:0]  w_lo_bp, w_lo_bg;
    logic [NBLK:0]    w_lo_bc;

    // Subtract is a + ~b + cin; the caller supplies cin = 1 for a plain a - b.
    assign w_b_eff = (in_op == OP_SUB) ? ~in_b : in_b;
    assign w_lo_p  = in_a[HALF-1:0] ^ w_b_eff[HALF-1:0];
    assign w_lo_g  = in_a[HALF-1:0] & w_b_eff[HALF-1:0];

    generate
        for (genvar k = 0; k < NBLK; k++) begin : g_lo_blk
            cla_blk4_pg u_blk (
                .p_i   (w_lo_p[k*BLK +: BLK]),
                .g_i   (w_lo_g[k*BLK +: BLK]),
                .cin_i (w_lo_bc[k]),
                .c_o   (w_lo_c[k*BLK+1 +: BLK-1]),
                .bp_o  (w_lo_bp[k]),
                .bg_o  (w_lo_bg[k])
            );
            assign w_lo_c[k*BLK] = w_lo_bc[k];
        end
    endgenerate

    // Block-level look-ahead for the low half; the top carry is c_mid.
    always_comb begin
        w_lo_bc[0] = in_cin;
        for (int k = 0; k < NBLK; k++) begin
            w_lo_bc[k+1] = w_lo_bg[k] | (w_lo_bp[k] & w_lo_bc[k]);
        end
    end

    assign w_lo_sum = w_lo_p ^ w_lo_c;

    // ---------------- stage 2: high-half add from registered operands -------
    logic [HALF-1:0]  r_lo_sum_q, r_a_hi_q, r_b_hi_q;
    logic             r_cmid_q;
    logic [HALF-1:0]  w_hi_p, w_hi_g, w_hi_c, w_hi_sum;
    logic [NBLK-1:0]  w_hi_bp, w_hi_bg;
    logic [NBLK:0]    w_hi_bc;

    assign w_hi_p = r_a_hi_q ^ r_b_hi_q;
    assign w_hi_g = r_a_hi_q & r_b_hi_q;

    generate
        for (genvar k = 0; k < NBLK; k++) begin : g_hi_blk
            cla_blk4_pg u_blk (
                .p_i   (w_hi_p[k*BLK +: BLK]),
                .g_i   (w_hi_g[k*BLK +: BLK]),
                .cin_i (w_hi_bc[k]),
                .c_o   (w_hi_c[k*BLK+1 +: BLK-1]),
                .bp_o  (w_hi_bp[k]),
                .bg_o  (w_hi_bg[k])
            );
            assign w_hi_c[k*BLK] = w_hi_bc[k];
        end
    endgenerate

    // Block-level look-ahead for the high half, seeded by the registered c_mid.
    always_comb begin
        w_hi_bc[0] = r_cmid_q;
        for (int k = 0; k < NBLK; k++) begin
            w_hi_bc[k+1] = w_hi_bg[k] | (w_hi_bp[k] & w_hi_bc[k]);
        end
    end

    assign w_hi_sum = w_hi_p ^ w_hi_c;

    // The operand sign bits are the MSBs of the registered high halves.
    logic w_ovf, w_zero;
    assign w_ovf  = (r_a_hi_q[HALF-1] == r_b_hi_q[HALF-1]) & (w_hi_sum[HALF-1] != r_a_hi_q[HALF-1]);
    assign w_zero = ~|{w_hi_sum, r_lo_sum_q};

    // ---------------- handshake ----------------
    logic r_s1_valid_q, r_out_valid_q;
    logic w_s1_valid_d, w_out_valid_d;
    logic w_s2_can_load, w_s1_load, w_s1_drain;

    assign w_s2_can_load = ~r_out_valid_q | out_ready;
    assign in_ready      = ~r_s1_valid_q | w_s2_can_load;
    assign w_s1_load     = in_valid & in_ready;
    assign w_s1_drain    = r_s1_valid_q & w_s2_can_load;

    // Valid flags: set on load, cleared when drained with nothing replacing.
    always_comb begin
        w_s1_valid_d  = r_s1_valid_q;
        w_out_valid_d = r_out_valid_q;
        if (w_s1_load) begin
            w_s1_valid_d = 1'b1;
        end else if (w_s1_drain) begin
            w_s1_valid_d = 1'b0;
        end
        if (w_s1_drain) begin
            w_out_valid_d = 1'b1;
        end else if (out_ready) begin
            w_out_valid_d = 1'b0;
        end
    end

    // Pipeline registers; reset discards any in-flight beats.
    logic [WIDTH-1:0] r_sum_q;
    logic             r_cout_q, r_ovf_q, r_zero_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid_q  <= 1'b0;
            r_out_valid_q <= 1'b0;
            r_lo_sum_q    <= '0;
            r_cmid_q      <= 1'b0;
            r_a_hi_q      <= '0;
            r_b_hi_q      <= '0;
            r_sum_q       <= '0;
            r_cout_q      <= 1'b0;
            r_ovf_q       <= 1'b0;
            r_zero_q      <= 1'b0;
        end else begin
            r_s1_valid_q  <= w_s1_valid_d;
            r_out_valid_q <= w_out_valid_d;
            if (w_s1_load) begin
                r_lo_sum_q <= w_lo_sum;
                r_cmid_q   <= w_lo_bc[NBLK];
                r_a_hi_q   <= in_a[WIDTH-1:HALF];
                r_b_hi_q   <= w_b_eff[WIDTH-1:HALF];
            end
            if (w_s1_drain) begin
                r_sum_q  <= {w_hi_sum, r_lo_sum_q};
                r_cout_q <= w_hi_bc[NBLK];
                r_ovf_q  <= w_ovf;
                r_zero_q <= w_zero;
            end
        end
    end

    assign out_valid = r_out_valid_q;
    assign out_sum   = r_sum_q;
    assign out_cout  = r_cout_q;
    assign out_ovf   = r_ovf_q;
    assign out_zero  = r_zero_q;

endmodule : pipe_addsub_32
`default_nettype wire

// File: tb/tb_pipe_addsub_32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_addsub_32
//  Description : Self-checking bench for pipe_addsub_32. A reference model
//                computes each result with integer arithmetic and treats the
//                block as a two-deep in-order queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_addsub_32;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_op, in_cin;
    logic [31:0] in_a, in_b;
    logic        out_valid, out_ready, out_cout, out_ovf, out_zero;
    logic [31:0] out_sum;

    always #5 clk = ~clk;

    pipe_addsub_32 #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          acc;     // cycle in which the beat was accepted
    } beat_t;

    beat_t q[$];
    int    cyc;
    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_out;

    // Values observed before the edge and what the model expects of them.
    logic        o_rdy, o_ov, o_cout, o_ovf, o_zero;
    logic [31:0] o_sum;
    logic        e_rdy, e_ov, e_acc;
    beat_t       e_front;

    // Plain integer arithmetic: add is a+b+cin, subtract is a-b-borrow
    // where borrow = !cin. Overflow is the exact signed result leaving range.
    function automatic beat_t ref_model(input logic op, input logic [31:0] a,
                                        input logic [31:0] b, input logic cin);
        beat_t  r;
        longint ua, ub, u, sa, sb, s;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op) begin
            u = ua - ub - longint'(!cin);
            s = sa - sb - longint'(!cin);
            r.cout = (u >= 0);
        end else begin
            u = ua + ub + longint'(cin);
            s = sa + sb + longint'(cin);
            r.cout = (u >= 64'sd4294967296);
        end
        r.sum  = u[31:0];
        r.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        r.zero = (r.sum == 32'd0);
        r.acc  = 0;
        return r;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h0000_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // One clock cycle: drive, sample, advance the model, cross the edge.
    task automatic step(input logic v, input logic op, input logic [31:0] a,
                        input logic [31:0] b, input logic cin, input logic ordy);
        beat_t nb;
        in_valid = v; in_op = op; in_a = a; in_b = b; in_cin = cin; out_ready = ordy;
        #1;
        o_rdy = in_ready; o_ov = out_valid; o_sum = out_sum;
        o_cout = out_cout; o_ovf = out_ovf; o_zero = out_zero;
        e_rdy = (q.size() < 2) || ordy;
        e_ov  = (q.size() > 0) && (cyc - q[0].acc >= 2);
        if (q.size() > 0) e_front = q[0];
        e_acc = v && e_rdy;
        if (e_ov && ordy) begin
            void'(q.pop_front());
            n_out++;
        end
        if (e_acc) begin
            nb = ref_model(op, a, b, cin);
            nb.acc = cyc;
            q.push_back(nb);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        cyc = 0;
    endtask

    task automatic test_reset();
        apply_reset(3);
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset in_ready got=%b exp=1", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset out_valid got=%b exp=0", out_valid); else n_pass++;
        n_checks++; if (out_sum !== 32'd0) $display("FAIL reset out_sum got=%h exp=0", out_sum); else n_pass++;
        n_checks++; if (out_cout !== 1'b0) $display("FAIL reset out_cout got=%b exp=0", out_cout); else n_pass++;
        n_checks++; if (out_ovf !== 1'b0) $display("FAIL reset out_ovf got=%b exp=0", out_ovf); else n_pass++;
        n_checks++; if (out_zero !== 1'b0) $display("FAIL reset out_zero got=%b exp=0", out_zero); else n_pass++;
    endtask

    // Hand-computed corner cases, each checked for two-cycle latency.
    task automatic test_directed();
        logic        t_op[4]   = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] t_a[4]    = '{32'h0000_0001, 32'd5, 32'h8000_0000, 32'h0000_FFFF};
        logic [31:0] t_b[4]    = '{32'hFFFF_FFFF, 32'd7, 32'd1, 32'h0000_0001};
        logic        t_cin[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] t_sum[4]  = '{32'h0000_0000, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h0001_0000};
        logic [2:0]  t_flg[4]  = '{3'b101, 3'b000, 3'b110, 3'b000};   // {cout, ovf, zero}
        for (int i = 0; i < 4; i++) begin
            step(1'b1, t_op[i], t_a[i], t_b[i], t_cin[i], 1'b1);
            step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
            n_checks++;
            if (o_ov !== 1'b0) $display("FAIL directed%0d early out_valid got=%b exp=0", i, o_ov); else n_pass++;
            step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
            n_checks++;
            if (o_ov !== 1'b1) $display("FAIL directed%0d out_valid got=%b exp=1", i, o_ov); else n_pass++;
            n_checks++;
            if (o_sum !== t_sum[i]) $display("FAIL directed%0d sum got=%h exp=%h", i, o_sum, t_sum[i]); else n_pass++;
            n_checks++;
            if ({o_cout, o_ovf, o_zero} !== t_flg[i])
                $display("FAIL directed%0d flags(cout,ovf,zero) got=%b exp=%b", i, {o_cout, o_ovf, o_zero}, t_flg[i]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        n_out = 0;
        for (int c = 0; c < 24; c++) begin
            step(c < 16, 1'($urandom_range(0, 1)), pick_operand(), pick_operand(), 1'($urandom_range(0, 1)), 1'b1);
            n_checks++; if (o_rdy !== e_rdy) $display("FAIL stream c%0d in_ready got=%b exp=%b", c, o_rdy, e_rdy); else n_pass++;
            n_checks++; if (o_ov !== e_ov) $display("FAIL stream c%0d out_valid got=%b exp=%b", c, o_ov, e_ov); else n_pass++;
            if (e_ov) begin
                n_checks++;
                if ({o_sum, o_cout, o_ovf, o_zero} !== {e_front.sum, e_front.cout, e_front.ovf, e_front.zero})
                    $display("FAIL stream c%0d result got=%h/%b%b%b exp=%h/%b%b%b", c, o_sum, o_cout, o_ovf, o_zero,
                             e_front.sum, e_front.cout, e_front.ovf, e_front.zero);
                else n_pass++;
            end
        end
        n_checks++; if (n_out !== 16) $display("FAIL stream result count got=%0d exp=16", n_out); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [31:0] ba[4], bb[4];
        logic        bo[4];
        int          idx = 0;
        int          n_acc_stall = 0;
        for (int i = 0; i < 4; i++) begin
            ba[i] = $urandom; bb[i] = $urandom; bo[i] = 1'($urandom_range(0, 1));
        end
        n_out = 0;
        for (int c = 0; c < 14; c++) begin
            step(idx < 3, bo[idx], ba[idx], bb[idx], 1'b1, c >= 6);
            if (e_acc) idx++;
            if (e_acc && c < 6) n_acc_stall++;
            n_checks++; if (o_rdy !== e_rdy) $display("FAIL bp c%0d in_ready got=%b exp=%b", c, o_rdy, e_rdy); else n_pass++;
            n_checks++; if (o_ov !== e_ov) $display("FAIL bp c%0d out_valid got=%b exp=%b", c, o_ov, e_ov); else n_pass++;
            if (e_ov) begin
                n_checks++;
                if ({o_sum, o_cout, o_ovf, o_zero} !== {e_front.sum, e_front.cout, e_front.ovf, e_front.zero})
                    $display("FAIL bp c%0d result got=%h/%b%b%b exp=%h/%b%b%b", c, o_sum, o_cout, o_ovf, o_zero,
                             e_front.sum, e_front.cout, e_front.ovf, e_front.zero);
                else n_pass++;
            end
        end
        n_checks++; if (n_acc_stall !== 2) $display("FAIL bp accepted while stalled got=%0d exp=2", n_acc_stall); else n_pass++;
        n_checks++; if (n_out !== 3) $display("FAIL bp drained count got=%0d exp=3", n_out); else n_pass++;
    endtask

    task automatic test_random();
        n_out = 0;
        for (int c = 0; c < 320; c++) begin
            step(c < 300 && $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), pick_operand(), pick_operand(),
                 1'($urandom_range(0, 1)), c >= 300 || $urandom_range(0, 3) != 0);
            n_checks++; if (o_rdy !== e_rdy) $display("FAIL random c%0d in_ready got=%b exp=%b", c, o_rdy, e_rdy); else n_pass++;
            n_checks++; if (o_ov !== e_ov) $display("FAIL random c%0d out_valid got=%b exp=%b", c, o_ov, e_ov); else n_pass++;
            if (e_ov) begin
                n_checks++;
                if ({o_sum, o_cout, o_ovf, o_zero} !== {e_front.sum, e_front.cout, e_front.ovf, e_front.zero})
                    $display("FAIL random c%0d result got=%h/%b%b%b exp=%h/%b%b%b", c, o_sum, o_cout, o_ovf, o_zero,
                             e_front.sum, e_front.cout, e_front.ovf, e_front.zero);
                else n_pass++;
            end
        end
        n_checks++; if (q.size() !== 0) $display("FAIL random undrained beats got=%0d exp=0", q.size()); else n_pass++;
    endtask

    task automatic test_reset_midflight();
        step(1'b1, 1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0001, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        n_checks++; if (o_ov !== 1'b1 || o_rdy !== 1'b0)
            $display("FAIL midreset fill valid/ready got=%b%b exp=10", o_ov, o_rdy); else n_pass++;
        reset = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL midreset out_valid got=%b exp=0", out_valid); else n_pass++;
        n_checks++; if ({out_sum, out_cout, out_ovf, out_zero} !== 35'd0)
            $display("FAIL midreset outputs got=%h/%b%b%b exp=0", out_sum, out_cout, out_ovf, out_zero); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL midreset in_ready got=%b exp=1", in_ready); else n_pass++;
        reset = 1'b0;
        q.delete();
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
            n_checks++; if (o_ov !== 1'b0) $display("FAIL midreset stale c%0d out_valid got=%b exp=0", c, o_ov); else n_pass++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0;
        n_out = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pipe_addsub_32
`default_nettype wire
